ixc_assign48_rr_arb: RTL and testbench
======================================

// Module: ixc_assign48_rr_arb
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 48-bit assign datapath.
//  Up to NREQ requesters compete for one 48-bit L-side bus. The winner's R-side word
//  is captured into a single registered output stage with a valid/ready handshake.
//  Sits in front of the ixc_assign_48 bus, so one physical 48-bit path serves several sources.
// PARAMETERS
//  NREQ   4   number of requesters, 2..16
//  WIDTH  48  data width per requester; fixed at 48 for this datapath
//  IDW    2   id width, = $clog2(NREQ); set by the instantiating module
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  req_valid  in   NREQ        requester i has a word
//  req_data   in   NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ        word from requester i accepted this cycle
//  req_last   in   NREQ        last beat of burst (only with IXC_ASSIGN_ARB_LOCK_EN)
//  out_valid  out  1           out_data/out_id hold a word
//  out_data   out  WIDTH       granted word (drives the assign bus R side)
//  out_id     out  IDW         index of the requester that supplied out_data
//  out_ready  in   1           consumer takes the word this cycle
//  busy       out  1           out_valid | any req_valid | locked
// BEHAVIOUR
//  - Reset, asynchronous while rst_n=0:
//    - out_valid=0, out_data=0, out_id=0.
//    - rr pointer=0, so requester 0 has highest priority first; lock state cleared.
//    - req_ready=0 during reset.
//  - load = (!out_valid | out_ready) & |eligible.
//  - Grant: one-hot, combinational.
//    - First eligible requester scanning ptr, ptr+1, ... NREQ-1, 0 .. ptr-1.
//  - req_ready = grant & {NREQ{load}}. At most one bit is high per cycle.
//  - On load: out_data <= winner's word; out_id <= winner index; out_valid <= 1.
//    - ptr <= winner+1, wrapping to 0 after NREQ-1.
//  - If out_valid & out_ready & no load: out_valid <= 0. out_data/out_id keep their last value.
//  - Stall: while out_valid & !out_ready, out_data and out_id hold stable and all req_ready=0.
//  - Latency: accept in cycle N gives out_valid in cycle N+1.
//    - Full throughput: one word per cycle when out_ready stays 1.
//  - Simultaneous out_ready and new request in the same cycle: the new word replaces the old word. No bubble.
//  - A requester that drops req_valid before its grant is skipped. Nothing is latched for it.
//  - Without lock, eligible = req_valid, and every beat is an arbitration point.
//  - busy=0 only when fully idle. It is purely combinational from registers and inputs.
// CONFIGURATION
//  IXC_ASSIGN_ARB_LOCK_EN defined:
//   - The req_last port exists.
//   - FSM states: ARB, LOCK.
//     - ARB -> LOCK when a beat from i is accepted with req_last[i]=0; lock_id <= i.
//     - LOCK -> ARB when a beat from lock_id is accepted with req_last=1.
//   - In LOCK, eligible = req_valid & onehot(lock_id). Other requesters get no grant
//     even if lock_id is idle.
//   - ptr updates only on the last beat. The burst counts as one turn.
//   - Reset mid-burst returns to ARB with ptr=0.
//  IXC_ASSIGN_ARB_LOCK_EN undefined:
//   - No req_last port and no FSM. Arbitration is per beat as described above.
// TESTING
//  1 Reset: hold rst_n=0 with all req_valid=1.
//    -> out_valid=0, req_ready=0. First accept after release goes to req 0; out_id=0 one cycle later.
//  2 Fairness: all 4 req_valid=1, out_ready=1 for 8 cycles.
//    -> out_id sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
//  3 Backpressure: req2 data=48'hA5A5_0000_1234, out_ready=0 for 5 cycles.
//    -> out_data stable at that value and req_ready=0 throughout. One accept after out_ready=1.
//  4 Wrap/skip: ptr=3, only req1 valid.
//    -> grant req1, then ptr=2. With req0 and req3 valid next, req3 wins.
//  5 Drop: req1 drops valid while stalled.
//    -> no word from req1 appears. The next grant goes to the next valid requester.
//  6 LOCK_EN: req0 sends a 3-beat burst (last on beat 3) while req1 is valid.
//    -> out_id 0,0,0 then 1. Asserting rst_n=0 mid-burst -> ARB, ptr=0, out_valid=0.

Source files
------------

// File: rtl/ixc_assign48_rr_arb.sv
// Round-robin arbiter feeding one registered 48-bit output stage (valid/ready).
// Define IXC_ASSIGN_ARB_LOCK_EN to add req_last and burst locking (ARB/LOCK FSM).
module ixc_assign48_rr_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 48,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
`ifdef IXC_ASSIGN_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_last,
`endif
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready,
  output logic                  busy
);

  logic [IDW-1:0]   r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDW-1:0]   r_out_id;

  logic [NREQ-1:0]  w_eligible;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_win_id;
  logic             w_found;
  logic             w_load;
  logic             w_ptr_upd;
  logic             w_locked;
  logic [IDW-1:0]   w_ptr_nxt;

`ifdef IXC_ASSIGN_ARB_LOCK_EN
  typedef enum logic {ARB, LOCK} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_lock_id, w_lock_id_nxt;

  // Eligibility depends only on registered state, keeping grant/load loop-free.
  always_comb begin
    w_eligible = req_valid;
    if (r_state == LOCK)
      w_eligible = req_valid & (NREQ'(1) << r_lock_id);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_ptr_upd     = w_load & req_last[w_win_id];
    case (r_state)
      ARB: begin
        if (w_load && !req_last[w_win_id]) begin
          w_state_nxt   = LOCK;
          w_lock_id_nxt = w_win_id;
        end
      end
      LOCK: begin
        if (w_load && req_last[w_win_id])
          w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  assign w_locked = (r_state == LOCK);
`else
  assign w_eligible = req_valid;
  assign w_ptr_upd  = w_load;
  assign w_locked   = 1'b0;
`endif

  // First eligible requester scanning from r_ptr upward with wrap.
  always_comb begin
    int unsigned w_idx;
    w_idx    = 0;
    w_grant  = '0;
    w_win_id = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && w_eligible[w_idx]) begin
        w_found         = 1'b1;
        w_grant[w_idx]  = 1'b1;
        w_win_id        = IDW'(w_idx);
      end
    end
  end

  assign w_load    = (!r_out_valid || out_ready) && w_found;
  assign w_ptr_nxt = (w_win_id == IDW'(NREQ - 1)) ? '0 : w_win_id + 1'b1;
  assign req_ready = w_grant & {NREQ{w_load & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= req_data[w_win_id*WIDTH +: WIDTH];
      r_out_id    <= w_win_id;
      if (w_ptr_upd)
        r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = r_out_valid | (|req_valid) | w_locked;

endmodule

// File: tb/tb_ixc_assign48_rr_arb.sv
// Scoreboard bench for ixc_assign48_rr_arb: stimulus queues expected {id,data},
// a monitor pops on every out_valid & out_ready transfer.
module tb_ixc_assign48_rr_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 48;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_last;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;
  logic                  busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [IDW+WIDTH-1:0] exp_q[$];

  ixc_assign48_rr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef IXC_ASSIGN_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] w(input int i, input int b);
    return {16'hC0DE, 8'(i), 8'(b), 16'h0BEE};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_word(input int i, input logic [WIDTH-1:0] v);
    exp_q.push_back({IDW'(i), v});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_word: got id %0d data %h expected no word at %0t", out_id, out_data, $time);
      end else begin
        check("out_word", 64'({out_id, out_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    out_ready = 1'b1;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) set_word(i, w(i, 0));

    // Reset with all requesters valid
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_out_id",    64'(out_id),    64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);

    // Fairness: 0,1,2,3,0,1,2,3 back to back
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) expect_word(i, w(i, 0));
    @(negedge clk);
    check("first_grant", 64'(req_ready), 64'b0001);
    repeat (8) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("full_rate_valid", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_busy",      64'(busy),      64'd0);

    // Backpressure: word from req2 held for 5 stalled cycles
    tick();
    set_word(2, 48'hA5A5_0000_1234);
    req_valid = 4'b0100;
    out_ready = 1'b0;
    expect_word(2, 48'hA5A5_0000_1234);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_data",  64'(out_data),  64'hA5A5_0000_1234);
      check("stall_id",    64'(out_id),    64'd2);
      check("stall_ready", 64'(req_ready), 64'd0);
    end
    check("stall_busy", 64'(busy), 64'd1);
    tick();
    out_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("drain_ready", 64'(req_ready), 64'd0);
    tick();

    // Wrap/skip: ptr=3, req1 alone, then req0+req3 -> req3
    set_word(1, w(1, 1));
    set_word(3, w(3, 1));
    set_word(0, w(0, 1));
    req_valid = 4'b0010;
    expect_word(1, w(1, 1));
    @(negedge clk);
    check("wrap_grant1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b1001;
    expect_word(3, w(3, 1));
    @(negedge clk);
    check("wrap_grant3", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    check("wrap_idle", 64'(out_valid), 64'd0);

    // Drop: req1 withdraws while stalled, req2 replaces the held word with no bubble
    tick();
    set_word(0, w(0, 2));
    set_word(1, w(1, 2));
    set_word(2, w(2, 2));
    req_valid = 4'b0001;
    out_ready = 1'b0;
    expect_word(0, w(0, 2));
    tick();
    req_valid = 4'b0110;
    repeat (2) begin
      @(negedge clk);
      check("drop_stall_ready", 64'(req_ready), 64'd0);
      check("drop_stall_id",    64'(out_id),    64'd0);
    end
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    check("drop_stall_ready2", 64'(req_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    expect_word(2, w(2, 2));
    @(negedge clk);
    check("drop_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("no_bubble", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    check("drop_idle", 64'(out_valid), 64'd0);

`ifdef IXC_ASSIGN_ARB_LOCK_EN
    // Burst from req0 locks out req1 until its last beat
    tick();
    set_word(0, w(0, 11));
    set_word(1, w(1, 9));
    req_valid = 4'b0011;
    req_last  = 4'b1110;
    expect_word(0, w(0, 11));
    @(negedge clk);
    check("lock_beat1", 64'(req_ready), 64'b0001);
    tick();
    set_word(0, w(0, 12));
    expect_word(0, w(0, 12));
    @(negedge clk);
    check("lock_beat2", 64'(req_ready), 64'b0001);
    check("lock_busy",  64'(busy),      64'd1);
    tick();
    set_word(0, w(0, 13));
    req_last = 4'b1111;
    expect_word(0, w(0, 13));
    tick();
    expect_word(1, w(1, 9));
    @(negedge clk);
    check("lock_release", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();

    // Reset mid-burst clears lock and pointer
    set_word(0, w(0, 4));
    req_valid = 4'b0001;
    req_last  = 4'b1110;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_data",  64'(out_data),  64'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1010;
    req_last  = 4'b1111;
    expect_word(1, w(1, 9));
    @(negedge clk);
    check("midrst_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
